mul_seq: RTL

Multi-cycle multiply sequencer for the stage-2 execute path. It accepts `muli` (0x72) and `mulii` (0x73) operations from the pipeline and runs a shift-add multiplier datapath under a small state machine. It returns a truncated product together with its destination register number. While an operation is in flight it holds `busy` high, so the pipeline freezes stages 0–1 and does not issue a dependent instruction.

---
 rtl/mul_seq.sv | 80 ++++++++
 1 files changed

// File: rtl/mul_seq.sv
// mul_seq: multi-cycle shift-add multiplier for muli (16-bit) and mulii (paired 8-bit)
module mul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  op,
    input  logic [15:0] rd,
    input  logic [15:0] rs,
    input  logic [3:0]  dst,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [3:0]  result_reg,
    output logic        illegal
);
    localparam logic [7:0] MULI_OP  = 8'h72;
    localparam logic [7:0] MULII_OP = 8'h73;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [15:0] mcand, mplier, acc;
    logic [15:0] acc_n, mcand_n, mplier_n;
    logic [4:0]  cnt;
    logic [3:0]  dreg;
    logic        pair, accept, legal;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // paired mode keeps carries and shifts inside each 8-bit lane
    always_comb begin
        accept   = start && (state == IDLE || state == DONE);
        legal    = (op == MULI_OP) || (op == MULII_OP);
        acc_n    = pair ? {acc[15:8] + (mplier[8] ? mcand[15:8] : 8'h00),
                           acc[7:0]  + (mplier[0] ? mcand[7:0]  : 8'h00)}
                        : acc + (mplier[0] ? mcand : 16'h0000);
        mcand_n  = pair ? {mcand[14:8], 1'b0, mcand[6:0], 1'b0} : {mcand[14:0], 1'b0};
        mplier_n = pair ? {1'b0, mplier[15:9], 1'b0, mplier[7:1]} : {1'b0, mplier[15:1]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            mcand      <= 16'h0000;
            mplier     <= 16'h0000;
            acc        <= 16'h0000;
            cnt        <= 5'd0;
            dreg       <= 4'h0;
            pair       <= 1'b0;
            result     <= 16'h0000;
            result_reg <= 4'h0;
            illegal    <= 1'b0;
        end else begin
            illegal <= accept && !legal;
            if (accept && legal) begin
                state  <= RUN;
                mcand  <= rd;
                mplier <= rs;
                dreg   <= dst;
                pair   <= (op == MULII_OP);
                acc    <= 16'h0000;
                cnt    <= (op == MULII_OP) ? 5'd8 : 5'd16;
            end else if (state == RUN) begin
                acc    <= acc_n;
                mcand  <= mcand_n;
                mplier <= mplier_n;
                cnt    <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    state      <= DONE;
                    result     <= acc_n;
                    result_reg <= dreg;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule
